// File: rtl/proc_pkg.sv
// Shared definitions for the processor control unit.
// Holds the opcode constants, the state encoding and the one-hot bus-select
// codes. Also provides a helper that classifies the two-operand ALU opcodes.
package proc_pkg;

    // Instruction word layout: [8:6] opcode, [5:3] X, [2:0] Y
    localparam int IR_W  = 9;
    localparam int OP_W  = 3;
    localparam int IDX_W = 3;
    localparam int NREGS = 8;

    localparam logic [OP_W-1:0] OP_MV  = 3'b000;
    localparam logic [OP_W-1:0] OP_MVI = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB = 3'b011;

    // One-hot bus mux selects
    localparam logic [2:0] SEL_REG = 3'b001;
    localparam logic [2:0] SEL_DIN = 3'b010;
    localparam logic [2:0] SEL_G   = 3'b100;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    // add and sub take the three-step A/G path
    function automatic logic is_arith(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-bit index to 8-bit one-hot decoder with enable.
// Ports:
//   en  - when low the output is all zero
//   idx - index of the bit to assert
//   dec - one-hot output (or zero)
module dec3to8
    import proc_pkg::*;
(
    input  logic             en,
    input  logic [IDX_W-1:0] idx,
    output logic [NREGS-1:0] dec
);

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_dec
            assign dec[gi] = en && (idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/proc_ctrl.sv
// Control unit for a small multi-cycle processor (mv, mvi, add, sub).
// Ports:
//   clk        - clock, all state updates on rising edge
//   rst_n      - asynchronous active-low reset
//   run        - start request, sampled in T0 only
//   ir_in      - instruction word {opcode, X, Y}
//   ir_load    - instruction is captured at this cycle's rising edge
//   bus_sel    - one-hot bus select {G, DIN, register file}
//   reg_rd_sel - register driving the register-file bus input
//   reg_wr_en  - one-hot register write enable, or zero
//   a_load     - load ALU operand A from the bus
//   g_load     - load ALU result G
//   alu_sub    - subtract when set, add otherwise
//   done       - final cycle of an instruction
//   busy       - state is not T0
module proc_ctrl
    import proc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [IR_W-1:0]  ir_in,
    output logic             ir_load,
    output logic [2:0]       bus_sel,
    output logic [IDX_W-1:0] reg_rd_sel,
    output logic [NREGS-1:0] reg_wr_en,
    output logic             a_load,
    output logic             g_load,
    output logic             alu_sub,
    output logic             done,
    output logic             busy
);

    state_t          state_reg;
    state_t          state_next;
    logic [IR_W-1:0] ir_reg;

    logic [OP_W-1:0]  opcode;
    logic [IDX_W-1:0] rx;
    logic [IDX_W-1:0] ry;
    logic             wr_req;

    assign opcode = ir_reg[8:6];
    assign rx     = ir_reg[5:3];
    assign ry     = ir_reg[2:0];

    // rst_n gates the strobe so it stays low for the whole time reset is held,
    // even though the reset state T0 would otherwise pass run straight through.
    assign ir_load = (state_reg == T0) && run && rst_n;
    assign busy    = (state_reg != T0);

    // State register and instruction register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= T0;
            ir_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (ir_load) begin
                ir_reg <= ir_in;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            T0: state_next = run ? T1 : T0;
            T1: state_next = is_arith(opcode) ? T2 : T0;
            T2: state_next = T3;
            T3: state_next = T0;
            default: state_next = T0;
        endcase
    end

    // Output logic; depends on state and IR only (ir_load excepted)
    always_comb begin
        bus_sel    = SEL_REG;
        reg_rd_sel = '0;
        wr_req     = 1'b0;
        a_load     = 1'b0;
        g_load     = 1'b0;
        alu_sub    = 1'b0;
        done       = 1'b0;
        case (state_reg)
            T1: begin
                case (opcode)
                    OP_MV: begin
                        reg_rd_sel = ry;
                        wr_req     = 1'b1;
                        done       = 1'b1;
                    end
                    OP_MVI: begin
                        bus_sel = SEL_DIN;
                        wr_req  = 1'b1;
                        done    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        reg_rd_sel = rx;
                        a_load     = 1'b1;
                    end
                    // Illegal opcodes finish immediately without side effects
                    default: done = 1'b1;
                endcase
            end
            T2: begin
                reg_rd_sel = ry;
                g_load     = 1'b1;
                alu_sub    = (opcode == OP_SUB);
            end
            T3: begin
                bus_sel = SEL_G;
                wr_req  = 1'b1;
                done    = 1'b1;
            end
            default: ;
        endcase
    end

    // Every register write targets Rx
    dec3to8 u_wr_dec (
        .en  (wr_req),
        .idx (rx),
        .dec (reg_wr_en)
    );

endmodule

// File: tb/tb_proc_ctrl.sv
// Directed testbench for proc_ctrl.
module tb_proc_ctrl;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [8:0] ir_in;
    logic       ir_load;
    logic [2:0] bus_sel;
    logic [2:0] reg_rd_sel;
    logic [7:0] reg_wr_en;
    logic       a_load;
    logic       g_load;
    logic       alu_sub;
    logic       done;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    proc_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .ir_in      (ir_in),
        .ir_load    (ir_load),
        .bus_sel    (bus_sel),
        .reg_rd_sel (reg_rd_sel),
        .reg_wr_en  (reg_wr_en),
        .a_load     (a_load),
        .g_load     (g_load),
        .alu_sub    (alu_sub),
        .done       (done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-cycle invariants: bus_sel one-hot, reg_wr_en zero or one-hot
    always @(negedge clk) begin
        checks++;
        if ($countones(bus_sel) != 1) begin
            failures++;
            $display("FAIL onehot_bus_sel got=%b required=one-hot", bus_sel);
        end
        checks++;
        if ($countones(reg_wr_en) > 1) begin
            failures++;
            $display("FAIL onehot_wr_en got=%b required=zero-or-one-hot", reg_wr_en);
        end
    end

    // Advance to 1 time unit past the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        run   = 1'b1;
        ir_in = 9'b010_011_011;
        #2;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (ir_load !== 1'b0) begin failures++; $display("FAIL rst_ir_load got=%b exp=0", ir_load); end
        checks++; if (bus_sel !== 3'b001) begin failures++; $display("FAIL rst_bus_sel got=%b exp=001", bus_sel); end
        checks++; if (reg_wr_en !== 8'h00) begin failures++; $display("FAIL rst_wr_en got=%h exp=00", reg_wr_en); end
        checks++; if ({a_load, g_load, alu_sub, done} !== 4'b0000) begin failures++; $display("FAIL rst_ctrl got=%b exp=0000", {a_load, g_load, alu_sub, done}); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_hold_busy got=%b exp=0", busy); end
        run = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_mvi();
        run   = 1'b1;
        ir_in = 9'b001_010_000;
        #1;
        checks++; if (ir_load !== 1'b1) begin failures++; $display("FAIL mvi_ir_load got=%b exp=1", ir_load); end
        tick();
        run   = 1'b0;
        ir_in = 9'b000_111_111;
        #1;
        checks++; if (bus_sel !== 3'b010) begin failures++; $display("FAIL mvi_bus_sel got=%b exp=010", bus_sel); end
        checks++; if (reg_wr_en !== 8'h04) begin failures++; $display("FAIL mvi_wr_en got=%h exp=04", reg_wr_en); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL mvi_done got=%b exp=1", done); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mvi_busy got=%b exp=1", busy); end
        tick();
        checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL mvi_end got=%b exp=00", {busy, done}); end
        $display("mvi R2 transaction complete");
    endtask

    task automatic test_sub();
        run   = 1'b1;
        ir_in = 9'b011_001_101;
        #1;
        checks++; if (ir_load !== 1'b1) begin failures++; $display("FAIL sub_ir_load got=%b exp=1", ir_load); end
        tick();
        ir_in = 9'h1FF;   // must be ignored from T1 onwards
        #1;
        checks++; if (ir_load !== 1'b0) begin failures++; $display("FAIL sub_t1_ir_load got=%b exp=0", ir_load); end
        checks++; if ({a_load, reg_rd_sel, bus_sel} !== {1'b1, 3'd1, 3'b001}) begin failures++; $display("FAIL sub_t1 got=%b/%0d/%b exp=1/1/001", a_load, reg_rd_sel, bus_sel); end
        checks++; if ({done, g_load, reg_wr_en} !== 10'd0) begin failures++; $display("FAIL sub_t1_quiet got=%b/%b/%h exp=0/0/00", done, g_load, reg_wr_en); end
        tick();
        checks++; if ({g_load, alu_sub, reg_rd_sel, a_load} !== {1'b1, 1'b1, 3'd5, 1'b0}) begin failures++; $display("FAIL sub_t2 got=g%b s%b r%0d a%b exp=g1 s1 r5 a0", g_load, alu_sub, reg_rd_sel, a_load); end
        checks++; if ({done, reg_wr_en} !== 9'd0) begin failures++; $display("FAIL sub_t2_quiet got=%b/%h exp=0/00", done, reg_wr_en); end
        tick();
        run = 1'b0;
        #1;
        checks++; if (bus_sel !== 3'b100) begin failures++; $display("FAIL sub_t3_bus_sel got=%b exp=100", bus_sel); end
        checks++; if (reg_wr_en !== 8'h02) begin failures++; $display("FAIL sub_t3_wr_en got=%h exp=02", reg_wr_en); end
        checks++; if ({done, g_load} !== 2'b10) begin failures++; $display("FAIL sub_t3_done got=%b exp=10", {done, g_load}); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sub_end_busy got=%b exp=0", busy); end
        $display("sub R1,R5 transaction complete");
    endtask

    task automatic test_back_to_back();
        run   = 1'b1;
        ir_in = 9'b000_111_000;   // mv R7,R0
        #1;
        checks++; if (ir_load !== 1'b1) begin failures++; $display("FAIL b2b_mv_load got=%b exp=1", ir_load); end
        tick();
        ir_in = 9'b010_000_000;   // add R0,R0
        #1;
        checks++; if ({done, reg_wr_en, reg_rd_sel, bus_sel} !== {1'b1, 8'h80, 3'd0, 3'b001}) begin failures++; $display("FAIL b2b_mv_t1 got=%b/%h/%0d/%b exp=1/80/0/001", done, reg_wr_en, reg_rd_sel, bus_sel); end
        tick();
        checks++; if ({ir_load, busy} !== 2'b10) begin failures++; $display("FAIL b2b_add_load got=%b exp=10", {ir_load, busy}); end
        tick();
        checks++; if ({a_load, reg_rd_sel, done} !== {1'b1, 3'd0, 1'b0}) begin failures++; $display("FAIL b2b_add_t1 got=%b/%0d/%b exp=1/0/0", a_load, reg_rd_sel, done); end
        tick();
        checks++; if ({g_load, alu_sub, reg_rd_sel} !== {1'b1, 1'b0, 3'd0}) begin failures++; $display("FAIL b2b_add_t2 got=%b/%b/%0d exp=1/0/0", g_load, alu_sub, reg_rd_sel); end
        tick();
        run = 1'b0;
        #1;
        checks++; if ({done, reg_wr_en, bus_sel} !== {1'b1, 8'h01, 3'b100}) begin failures++; $display("FAIL b2b_add_t3 got=%b/%h/%b exp=1/01/100", done, reg_wr_en, bus_sel); end
        tick();
        $display("mv R7,R0 + add R0,R0 back-to-back complete");
    endtask

    task automatic test_illegal();
        run   = 1'b1;
        ir_in = 9'b110_011_010;
        tick();
        run = 1'b0;
        #1;
        checks++; if ({done, busy, reg_wr_en} !== {1'b1, 1'b1, 8'h00}) begin failures++; $display("FAIL ill_t1 got=%b/%b/%h exp=1/1/00", done, busy, reg_wr_en); end
        checks++; if ({a_load, g_load, bus_sel} !== {1'b0, 1'b0, 3'b001}) begin failures++; $display("FAIL ill_ctrl got=%b/%b/%b exp=0/0/001", a_load, g_load, bus_sel); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ill_end_busy got=%b exp=0", busy); end
        $display("illegal opcode 110 transaction complete");
    endtask

    task automatic test_reset_mid();
        run   = 1'b1;
        ir_in = 9'b010_100_010;   // add R4,R2
        tick();
        run = 1'b0;
        tick();                   // now in T2
        #1;
        checks++; if (g_load !== 1'b1) begin failures++; $display("FAIL rmid_pre_g_load got=%b exp=1", g_load); end
        rst_n = 1'b0;
        #1;                       // no clock edge in between
        checks++; if ({busy, g_load, done, a_load} !== 4'b0000) begin failures++; $display("FAIL rmid_async got=%b exp=0000", {busy, g_load, done, a_load}); end
        checks++; if ({reg_wr_en, bus_sel} !== {8'h00, 3'b001}) begin failures++; $display("FAIL rmid_async_bus got=%h/%b exp=00/001", reg_wr_en, bus_sel); end
        tick();                   // edge where T3 would have been entered
        checks++; if ({reg_wr_en, done, busy} !== 10'd0) begin failures++; $display("FAIL rmid_no_write got=%h/%b/%b exp=00/0/0", reg_wr_en, done, busy); end
        // Release with run high: ir_load follows immediately, state moves on next edge
        ir_in = 9'b001_110_000;   // mvi R6
        run   = 1'b1;
        #2;
        rst_n = 1'b1;
        #1;
        checks++; if ({ir_load, busy} !== 2'b10) begin failures++; $display("FAIL rmid_release got=%b exp=10", {ir_load, busy}); end
        tick();
        run = 1'b0;
        #1;
        checks++; if ({done, reg_wr_en, bus_sel} !== {1'b1, 8'h40, 3'b010}) begin failures++; $display("FAIL rmid_mvi got=%b/%h/%b exp=1/40/010", done, reg_wr_en, bus_sel); end
        tick();
        $display("reset during add T2 complete");
    endtask

    initial begin
        rst_n = 1'b0;
        run   = 1'b0;
        ir_in = '0;
        #3;
        test_reset();
        test_mvi();
        test_sub();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/proc_ctrl.md
PROC_CTRL -- requirements
Module: proc_ctrl

Interface
REQ-001 Parameters: none; the instruction format and register count are fixed.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 run  input  1  start request; sampled only in state T0.
REQ-005 ir_in  input  9  instruction word: [8:6] opcode, [5:3] X, [2:0] Y.
REQ-006 ir_load  output  1  strobe; the instruction is captured on this cycle's rising edge.
REQ-007 bus_sel  output  3  one-hot bus mux select: 001=register file, 010=immediate (DIN), 100=G (ALU result).
REQ-008 reg_rd_sel  output  3  index of the register driving bus input 0.
REQ-009 reg_wr_en  output  8  one-hot register write enable, or all zero.
REQ-010 a_load  output  1  load ALU operand register A from the bus.
REQ-011 g_load  output  1  load ALU result register G.
REQ-012 alu_sub  output  1  1 = subtract, 0 = add; meaningful only when g_load=1.
REQ-013 done  output  1  pulses high in the final cycle of each instruction.
REQ-014 busy  output  1  high whenever the state is not T0.

Function
REQ-015 States: T0, T1, T2, T3. Internal 9-bit IR is loaded from ir_in when ir_load=1.
REQ-016 Opcodes: 000 mv Rx,Ry; 001 mvi Rx,#D; 010 add Rx,Ry; 011 sub Rx,Ry; 100-111 illegal.
REQ-017 bus_sel shall be exactly one-hot in every cycle, including reset and T0; it is never 000 or multi-hot.
REQ-018 Default outputs: bus_sel=001, reg_rd_sel=0, reg_wr_en=0, a_load=g_load=alu_sub=done=ir_load=0.
REQ-019 T0: ir_load=run (combinational from run); run=1 -> T1, else stay in T0.
REQ-020 T1 mv: bus_sel=001, reg_rd_sel=Y, reg_wr_en[X]=1, done=1; -> T0.
REQ-021 T1 mvi: bus_sel=010, reg_wr_en[X]=1, done=1; -> T0.
REQ-022 T1 add/sub: bus_sel=001, reg_rd_sel=X, a_load=1; -> T2.
REQ-023 T1 illegal: defaults, done=1, no register write; -> T0.
REQ-024 T2: bus_sel=001, reg_rd_sel=Y, g_load=1, alu_sub=(opcode==011); -> T3.
REQ-025 T3: bus_sel=100, reg_wr_en[X]=1, done=1; -> T0.
REQ-026 Latency from the ir_load cycle to the done cycle: mv/mvi/illegal 1 cycle, add/sub 3 cycles.
REQ-027 run is ignored in T1-T3; IR is stable from T1 until the next T0 load.
REQ-028 Back-to-back: with run held at 1, a new instruction is loaded in the T0 cycle directly following done.
REQ-029 X==Y is legal: "add R3,R3" doubles R3 with no special casing.
REQ-030 Every output in T1-T3 is a function of state and IR only; ir_in changes there have no effect.

Reset
REQ-031 rst_n low shall immediately, without waiting for clk: force state T0, clear IR to 0, and drive the REQ-018 defaults with busy=0.
REQ-032 Reset asserted mid-instruction (T1-T3) aborts the instruction; no write enable is issued after the reset edge.
REQ-033 After rst_n deasserts, the first state update occurs on the next rising edge of clk.

Structure
REQ-034 Shared package proc_pkg holds the opcode constants, the state encoding, and the bus-select constants SEL_REG, SEL_DIN, SEL_G.
REQ-035 One sub-module, dec3to8 (3-bit index to 8-bit one-hot with enable), generates reg_wr_en.

Verification
REQ-036 Reset, then run=1 with ir_in=9'b001_010_000 (mvi R2) -> ir_load=1; next cycle bus_sel=010, reg_wr_en=8'h04, done=1.
REQ-037 ir_in=9'b011_001_101 (sub R1,R5) -> T1: a_load=1, reg_rd_sel=1; T2: g_load=1, alu_sub=1, reg_rd_sel=5; T3: bus_sel=100, reg_wr_en=8'h02, done=1.
REQ-038 mv R7,R0 followed by add R0,R0 with run held at 1 -> done pulses 1 and 3 cycles after their respective loads, with no idle cycle between the instructions.
REQ-039 Illegal opcode 9'b110_xxx_xxx -> done=1 in T1, reg_wr_en=0, state returns to T0.
REQ-040 rst_n pulsed low during T2 of an add -> outputs go to defaults asynchronously; no reg_wr_en pulse; busy=0.
REQ-041 A bench assertion on every cycle: bus_sel is one-hot and reg_wr_en is zero or one-hot.
